p_acc_seq: RTL and testbench
============================

Name: p_acc_seq

Overview:
- Multi-beat sequencer for the combinational accumulator datapath.
- Reduces a vector longer than IN lanes by feeding IN-wide chunks, one per handshake, into an internal accumulator instance of width IN+1.
- The extra lane carries the running partial sum.
- Sits between the weight-multiply stage and the activation stage of a time-multiplexed perceptron; owns all accumulation sequencing and flag collection.

Parameters:
- IN, 4, number of lanes consumed per beat.
- LEN_W, 8, width of beat-count field; max vector length is (2^LEN_W - 1) * IN.
- CONF, `DEF_DCONF, dconf_t data configuration (dtype, prec) passed unchanged to the accumulator.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a reduction; sampled only in IDLE.
- len  input  LEN_W  beat count for this reduction; sampled with start.
- in_valid  input  1  in_data holds a valid chunk.
- in_ready  output  1  block accepts a chunk this cycle.
- in_data  input  IN x CONF.prec  chunk of IN operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  CONF.prec  reduced sum.
- out_udf  output  1  sticky underflow over all beats.
- out_ovf  output  1  sticky overflow over all beats.
- out_rounded  output  1  sticky rounding over all beats.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state = IDLE, partial sum = 0, sticky flags = 0, count = 0. in_ready, out_valid and busy are 0; out_data and all flags read 0.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 and len!=0: load count=len, clear partial sum and flags, go to ACC.
  - start=1 and len=0: clear partial sum and flags, go straight to DONE (result 0, flags 0).
- ACC:
  - in_ready=1.
  - On in_valid & in_ready: the accumulator input vector is {partial, in_data[IN-1:0]}. The accumulator output is registered as the new partial sum, its udf/ovf/rounded are ORed into the sticky flags, and count decrements.
  - When count==1 at the handshake, go to DONE.
  - in_valid=0 stalls with no state change.
- DONE:
  - in_ready=0, out_valid=1, out_data = partial, flags = sticky values; all held stable until out_ready.
  - On out_valid & out_ready, go to IDLE. out_valid drops the next cycle.
- Latency:
  - The result is visible one cycle after the last input handshake.
  - Minimum reduction of len beats takes len+2 cycles from start to IDLE, assuming no stalls.
- start outside IDLE is ignored; len is ignored unless start is accepted.
- Arithmetic width and saturation/wrap follow the accumulator for CONF.dtype exactly. No widening; the partial sum stays CONF.prec.
- BOOL dtype: flags stay 0.
- Reset asserted mid-reduction or in DONE aborts to IDLE on the next edge. The partial result is discarded and no out_valid is produced.
- in_valid asserted outside ACC is ignored (in_ready=0).

Optional Feature:
- Macro: P_ACC_SEQ_BIAS_EN.
- Defined: adds input port bias [CONF.prec-1:0], sampled with start. On start, the partial sum is initialised to bias instead of 0. With len=0, DONE returns bias.
- Undefined: no bias port; the partial sum always starts at 0.

Decomposition:
- Shared package/header (perceptron.svh): dconf_t, dtype enum, `DEF_DCONF (existing), plus new enum p_acc_seq_state_t {IDLE, ACC, DONE}.
- `Enable/`Disable come from stddef.vh.
- Sub-module: one p_acc instance with IN+1 lanes is the natural, and only, child. No other submodules.

Test Plan:
- Test config: CONF INT, prec=8, IN=4.
- len=2 reduction: start, then chunks {1,2,3,4} and {5,6,7,8}, out_ready=1 -> out_valid one cycle after 2nd beat, out_data=36, all flags 0, busy drops next cycle.
- Overflow sticky: len=2, chunks {100,100,0,0} then {0,0,0,0} -> out_ovf=1 although the second beat alone does not overflow; out_data matches the INT accumulator rule.
- len=0: start with len=0 -> out_valid next cycle, out_data=0; with P_ACC_SEQ_BIAS_EN and bias=9, out_data=9.
- Back-pressure: len=1, chunk {1,1,1,1}, hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data stays 4; in_ready=0 throughout; start pulses are ignored.
- in_valid gaps: len=3, insert 2 idle cycles between beats of {1,1,1,1} -> out_data=12, count advances only on handshakes.
- Reset mid-op: len=3, reset after 1 beat -> next cycle busy=0, in_ready=0, out_valid=0; a new start with len=1 and {2,2,2,2} gives 8.

Source files
------------

// File: rtl/p_acc_seq_pkg.sv
// Shared types for the perceptron accumulation path: data configuration,
// dtype encoding, the default configuration and the sequencer state enum.
package p_acc_seq_pkg;

  typedef enum logic [1:0] {
    DT_BOOL,
    DT_INT,
    DT_UINT
  } dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic [7:0] prec;
  } dconf_t;

  localparam dconf_t DEF_DCONF = '{dtype: DT_INT, prec: 8'd8};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } p_acc_seq_state_t;

endpackage

// File: rtl/p_acc_seq_acc.sv
// Combinational N-lane accumulator. INT saturates signed, UINT saturates
// unsigned, BOOL is a logical OR of the lanes. Integer dtypes never round.
module p_acc_seq_acc
  import p_acc_seq_pkg::*;
#(
  parameter int     N    = 5,
  parameter dconf_t CONF = DEF_DCONF
) (
  input  logic [N-1:0][CONF.prec-1:0] lanes_i,
  output logic [CONF.prec-1:0]        sum_o,
  output logic                        udf_o,
  output logic                        ovf_o,
  output logic                        rounded_o
);

  localparam int P  = CONF.prec;
  // Full-precision sum needs clog2(N) growth bits plus a sign bit.
  localparam int SW = P + $clog2(N) + 1;

  localparam logic signed [SW-1:0] SMAX = $signed({{(SW-P+1){1'b0}}, {(P-1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = $signed({{(SW-P+1){1'b1}}, {(P-1){1'b0}}});
  localparam logic signed [SW-1:0] UMAX = $signed({{(SW-P){1'b0}}, {P{1'b1}}});

  function automatic logic signed [SW-1:0] ext(input logic [P-1:0] v, input logic sgn);
    return $signed({{(SW-P){sgn & v[P-1]}}, v});
  endfunction

  // Result packed as {udf, ovf, value}.
  function automatic logic [P+1:0] sat_int(input logic signed [SW-1:0] s);
    if (s > SMAX) return {2'b01, SMAX[P-1:0]};
    if (s < SMIN) return {2'b10, SMIN[P-1:0]};
    return {2'b00, s[P-1:0]};
  endfunction

  function automatic logic [P+1:0] sat_uint(input logic signed [SW-1:0] s);
    if (s > UMAX) return {2'b01, UMAX[P-1:0]};
    return {2'b00, s[P-1:0]};
  endfunction

  logic signed [SW-1:0] sum_full;
  logic                 any;
  logic [P+1:0]         res;

  // Sum all lanes at full precision, then saturate for the dtype.
  always_comb begin
    sum_full = '0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_full = sum_full + ext(lanes_i[i], CONF.dtype == DT_INT);
      any      = any | (|lanes_i[i]);
    end
    res = '0;
    case (CONF.dtype)
      DT_INT:  res = sat_int(sum_full);
      DT_UINT: res = sat_uint(sum_full);
      default: res[0] = any;
    endcase
  end

  assign sum_o     = res[P-1:0];
  assign ovf_o     = res[P];
  assign udf_o     = res[P+1];
  assign rounded_o = 1'b0;

endmodule

// File: rtl/p_acc_seq.sv
// Multi-beat reduction sequencer: folds IN-wide chunks into a running
// partial sum through one (IN+1)-lane accumulator, collecting sticky flags.
// Optional macro P_ACC_SEQ_BIAS_EN adds a bias port that seeds the partial sum.
module p_acc_seq
  import p_acc_seq_pkg::*;
#(
  parameter int     IN    = 4,
  parameter int     LEN_W = 8,
  parameter dconf_t CONF  = DEF_DCONF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN-1:0][CONF.prec-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CONF.prec-1:0]         out_data,
  output logic                         out_udf,
  output logic                         out_ovf,
  output logic                         out_rounded,
  output logic                         busy
`ifdef P_ACC_SEQ_BIAS_EN
  ,
  input  logic [CONF.prec-1:0]         bias
`endif
);

  localparam int P = CONF.prec;

  p_acc_seq_state_t state_q, state_d;
  logic [P-1:0]     partial_q, partial_d;
  logic             udf_q, udf_d, ovf_q, ovf_d, rnd_q, rnd_d;
  logic [LEN_W-1:0] count_q, count_d;

  logic [IN:0][P-1:0] acc_lanes;
  logic [P-1:0]       acc_sum;
  logic               acc_udf, acc_ovf, acc_rnd;
  logic [P-1:0]       init_sum;
  logic               beat;

  // Top lane carries the running partial sum.
  assign acc_lanes = {partial_q, in_data};
  assign beat      = (state_q == ACC) && in_valid;

`ifdef P_ACC_SEQ_BIAS_EN
  assign init_sum = bias;
`else
  assign init_sum = '0;
`endif

  p_acc_seq_acc #(
    .N    (IN + 1),
    .CONF (CONF)
  ) u_acc (
    .lanes_i   (acc_lanes),
    .sum_o     (acc_sum),
    .udf_o     (acc_udf),
    .ovf_o     (acc_ovf),
    .rounded_o (acc_rnd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: start in IDLE, count beats in ACC, wait for consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ACC;
      ACC:     if (beat && count_q == LEN_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath next state: seed on accepted start, fold in a chunk per beat.
  always_comb begin
    partial_d = partial_q;
    udf_d     = udf_q;
    ovf_d     = ovf_q;
    rnd_d     = rnd_q;
    count_d   = count_q;
    if (state_q == IDLE && start) begin
      partial_d = init_sum;
      udf_d     = 1'b0;
      ovf_d     = 1'b0;
      rnd_d     = 1'b0;
      count_d   = len;
    end else if (beat) begin
      partial_d = acc_sum;
      udf_d     = udf_q | acc_udf;
      ovf_d     = ovf_q | acc_ovf;
      rnd_d     = rnd_q | acc_rnd;
      count_d   = count_q - LEN_W'(1);
    end
  end

  // Datapath registers; reset discards any in-flight partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      partial_q <= '0;
      udf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rnd_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      partial_q <= partial_d;
      udf_q     <= udf_d;
      ovf_q     <= ovf_d;
      rnd_q     <= rnd_d;
      count_q   <= count_d;
    end
  end

  assign out_data    = partial_q;
  assign out_udf     = udf_q;
  assign out_ovf     = ovf_q;
  assign out_rounded = rnd_q;

endmodule

// File: tb/tb_p_acc_seq.sv
// Bench for p_acc_seq (INT, prec 8, IN 4): directed table, hand-written
// corner sequences and randomized reductions against a saturating-sum model.
module tb_p_acc_seq;
  import p_acc_seq_pkg::*;

  logic            clk = 1'b0;
  logic            reset, start, in_valid, out_ready;
  logic [7:0]      len;
  logic            in_ready, out_valid, out_udf, out_ovf, out_rounded, busy;
  logic [3:0][7:0] in_data;
  logic [7:0]      out_data;
`ifdef P_ACC_SEQ_BIAS_EN
  logic [7:0]      bias;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]           len;
    logic [7:0]           gap;
    logic [2:0][3:0][7:0] d;
    logic [7:0]           exp;
    logic                 ovf;
    logic                 udf;
  } vec_t;

  vec_t tbl[7];

  p_acc_seq #(.IN(4), .LEN_W(8), .CONF(DEF_DCONF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_udf     (out_udf),
    .out_ovf     (out_ovf),
    .out_rounded (out_rounded),
    .busy        (busy)
`ifdef P_ACC_SEQ_BIAS_EN
    ,
    .bias        (bias)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][7:0] mk(input int a, input int b, input int c, input int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int sat8(input int s, inout bit o, inout bit u);
    if (s > 127) begin o = 1'b1; return 127; end
    if (s < -128) begin u = 1'b1; return -128; end
    return s;
  endfunction

  // Reference: running signed sum, saturated to 8 bits after each beat.
  function automatic vec_t model(input vec_t v);
    int p = 0;
    int s;
    bit o = 1'b0;
    bit u = 1'b0;
    vec_t r = v;
    for (int b = 0; b < int'(v.len); b++) begin
      s = p;
      for (int l = 0; l < 4; l++) s += int'($signed(v.d[b][l]));
      p = sat8(s, o, u);
    end
    r.exp = 8'(p);
    r.ovf = o;
    r.udf = u;
    return r;
  endfunction

  // Start, feed v.len beats with v.gap idle cycles before each, hold result hold cycles.
  task automatic run_vec(input vec_t v, input int hold, input string nm);
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    len   = v.len;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < int'(v.len); b++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        in_valid = 1'b0;
        in_data  = 32'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = v.d[b];
      chk({nm, ".in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk({nm, ".hold_valid"}, out_valid, 1);
      chk({nm, ".hold_data"}, out_data, v.exp);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({nm, ".out_valid"}, out_valid, 1);
    chk({nm, ".out_data"}, out_data, v.exp);
    chk({nm, ".out_ovf"}, out_ovf, v.ovf);
    chk({nm, ".out_udf"}, out_udf, v.udf);
    chk({nm, ".out_rounded"}, out_rounded, 0);
    @(negedge clk);
    chk({nm, ".valid_drop"}, out_valid, 0);
    chk({nm, ".busy_drop"}, busy, 0);
  endtask

  initial begin
    vec_t v;
    int   exp0;

    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
`ifdef P_ACC_SEQ_BIAS_EN
    bias = '0;
`endif
    tbl[0] = '{len: 8'd2, gap: 8'd0, d: {mk(0,0,0,0), mk(5,6,7,8), mk(1,2,3,4)}, exp: 8'd36, ovf: 1'b0, udf: 1'b0};
    tbl[1] = '{len: 8'd2, gap: 8'd0, d: {mk(0,0,0,0), mk(0,0,0,0), mk(100,100,0,0)}, exp: 8'd127, ovf: 1'b1, udf: 1'b0};
    tbl[2] = '{len: 8'd3, gap: 8'd2, d: {mk(1,1,1,1), mk(1,1,1,1), mk(1,1,1,1)}, exp: 8'd12, ovf: 1'b0, udf: 1'b0};
    tbl[3] = '{len: 8'd1, gap: 8'd0, d: {mk(0,0,0,0), mk(0,0,0,0), mk(-100,-100,0,0)}, exp: 8'h80, ovf: 1'b0, udf: 1'b1};
    tbl[4] = '{len: 8'd2, gap: 8'd1, d: {mk(0,0,0,0), mk(-128,-128,-128,-128), mk(127,127,127,127)}, exp: 8'h80, ovf: 1'b1, udf: 1'b1};
    tbl[5] = '{len: 8'd1, gap: 8'd0, d: {mk(0,0,0,0), mk(0,0,0,0), mk(-1,-2,-3,-4)}, exp: 8'hF6, ovf: 1'b0, udf: 1'b0};
    tbl[6] = '{len: 8'd2, gap: 8'd0, d: {mk(0,0,0,0), mk(-50,-60,5,5), mk(10,20,30,40)}, exp: 8'd0, ovf: 1'b0, udf: 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.flags", {out_udf, out_ovf, out_rounded}, 0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) run_vec(tbl[i], 0, $sformatf("tbl%0d", i));

    // len = 0 goes straight to DONE
`ifdef P_ACC_SEQ_BIAS_EN
    bias = 8'd9;
    exp0 = 9;
`else
    exp0 = 0;
`endif
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0.out_valid", out_valid, 1);
    chk("len0.out_data", out_data, exp0);
    chk("len0.flags", {out_udf, out_ovf, out_rounded}, 0);
    @(negedge clk);
    chk("len0.valid_drop", out_valid, 0);
    chk("len0.busy_drop", busy, 0);
`ifdef P_ACC_SEQ_BIAS_EN
    bias = '0;
`endif

    // Back-pressure with ignored start / in_valid while DONE
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = mk(1,1,1,1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", out_valid, 1);
      chk("bp.out_data", out_data, 4);
      chk("bp.in_ready", in_ready, 0);
      start = 1'b1; len = 8'd5; in_valid = 1'b1; in_data = mk(9,9,9,9);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("bp.out_data_end", out_data, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.valid_drop", out_valid, 0);
    chk("bp.busy_drop", busy, 0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = mk(3,3,3,3);
    @(negedge clk);
    chk("idle.in_ready", in_ready, 0);
    chk("idle.busy", busy, 0);
    in_valid = 1'b0;

    // Reset mid-reduction
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = mk(1,1,1,1);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rmid.busy", busy, 0);
    chk("rmid.in_ready", in_ready, 0);
    chk("rmid.out_valid", out_valid, 0);
    chk("rmid.out_data", out_data, 0);
    reset = 1'b0;
    v = '{len: 8'd1, gap: 8'd0, d: {mk(0,0,0,0), mk(0,0,0,0), mk(2,2,2,2)}, exp: 8'd8, ovf: 1'b0, udf: 1'b0};
    run_vec(v, 0, "rmid.after");

    // Randomized reductions against the model
    for (int i = 0; i < 30; i++) begin
      v.len = 8'($urandom_range(1, 3));
      v.gap = 8'($urandom_range(0, 2));
      v.d   = 96'({$urandom, $urandom, $urandom});
      v     = model(v);
      run_vec(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
